// File: rtl/instr_decode.sv
// Instruction register and decoder for the multicycle MIPS control path.
// Ports: clk, rst, irWe, memData in; cmd, memCmd, fields, flags, instrCount out.
module instr_decode #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_IR = 32'h0000_0020
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irWe,
    input  logic [31:0]      memData,
    output logic [3:0]       cmd,
    output logic [3:0]       memCmd,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [31:0]      sxi,
    output logic [31:0]      sxis,
    output logic [25:0]      jAddr,
    output logic             illegal,
    output logic             illegalSticky,
    output logic [CNT_W-1:0] instrCount
);

    localparam logic [3:0] C_LW   = 4'd0;
    localparam logic [3:0] C_SW   = 4'd1;
    localparam logic [3:0] C_J    = 4'd2;
    localparam logic [3:0] C_JR   = 4'd3;
    localparam logic [3:0] C_JAL  = 4'd4;
    localparam logic [3:0] C_BEQ  = 4'd5;
    localparam logic [3:0] C_BNE  = 4'd6;
    localparam logic [3:0] C_XORI = 4'd7;
    localparam logic [3:0] C_ADDI = 4'd8;
    localparam logic [3:0] C_ADD  = 4'd9;
    localparam logic [3:0] C_SUB  = 4'd10;
    localparam logic [3:0] C_SLT  = 4'd11;
    localparam logic [3:0] C_ILL  = 4'd12;

    // Only op and funct matter; every other bit pattern falls to ILL.
    function automatic logic [3:0] dec(input logic [31:0] w);
        logic [3:0] c;
        c = C_ILL;
        case (w[31:26])
            6'h23: c = C_LW;
            6'h2B: c = C_SW;
            6'h02: c = C_J;
            6'h03: c = C_JAL;
            6'h04: c = C_BEQ;
            6'h05: c = C_BNE;
            6'h0E: c = C_XORI;
            6'h08: c = C_ADDI;
            6'h00: begin
                case (w[5:0])
                    6'h08:   c = C_JR;
                    6'h20:   c = C_ADD;
                    6'h22:   c = C_SUB;
                    6'h2A:   c = C_SLT;
                    default: c = C_ILL;
                endcase
            end
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    logic [31:0] ir;
    logic        memIll;

    // Look-ahead for the fetch state, before IR is written.
    assign memCmd = dec(memData);
    assign memIll = (memCmd == C_ILL);

    // cmd is decoded on the way in so it always matches IR.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir            <= RESET_IR;
            cmd           <= dec(RESET_IR);
            illegal       <= 1'b0;
            illegalSticky <= 1'b0;
            instrCount    <= '0;
        end else if (irWe) begin
            ir            <= memData;
            cmd           <= memCmd;
            illegal       <= memIll;
            illegalSticky <= illegalSticky | memIll;
            if (instrCount != {CNT_W{1'b1}})
                instrCount <= instrCount + 1'b1;
        end
    end

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign jAddr = ir[25:0];
    assign sxi   = {{16{ir[15]}}, ir[15:0]};
    assign sxis  = {{14{ir[15]}}, ir[15:0], 2'b00};

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode.
// Main instance uses default params; a second instance checks saturation.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        irWe;
    logic        irWeS;
    logic [31:0] memData;

    logic [3:0]  cmd, memCmd;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sxi, sxis;
    logic [25:0] jAddr;
    logic        illegal, illegalSticky;
    logic [15:0] instrCount;

    logic [3:0]  cmdS, memCmdS;
    logic [4:0]  rsS, rtS, rdS;
    logic [31:0] sxiS, sxisS;
    logic [25:0] jAddrS;
    logic        illegalS, illegalStickyS;
    logic [2:0]  instrCountS;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode u_dut (
        .clk(clk), .rst(rst), .irWe(irWe), .memData(memData),
        .cmd(cmd), .memCmd(memCmd), .rs(rs), .rt(rt), .rd(rd),
        .sxi(sxi), .sxis(sxis), .jAddr(jAddr), .illegal(illegal),
        .illegalSticky(illegalSticky), .instrCount(instrCount)
    );

    instr_decode #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .irWe(irWeS), .memData(memData),
        .cmd(cmdS), .memCmd(memCmdS), .rs(rsS), .rt(rtS), .rd(rdS),
        .sxi(sxiS), .sxis(sxisS), .jAddr(jAddrS), .illegal(illegalS),
        .illegalSticky(illegalStickyS), .instrCount(instrCountS)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w);
        memData = w;
        irWe    = 1'b1;
        tick();
        irWe    = 1'b0;
    endtask

    logic [5:0]  functs [4] = '{6'h08, 6'h20, 6'h22, 6'h2A};
    logic [3:0]  rcmds  [4] = '{4'd3, 4'd9, 4'd10, 4'd11};
    logic [31:0] mwords [8] = '{32'hAC000000, 32'h0C000000, 32'h14000000,
                                32'h38000000, 32'h00000160, 32'h00000021,
                                32'hFC000000, 32'h20000000};
    logic [3:0]  mcmds  [8] = '{4'd1, 4'd4, 4'd6, 4'd7, 4'd9, 4'd12,
                                4'd12, 4'd8};

    initial begin
        rst = 1'b1; irWe = 1'b1; irWeS = 1'b0; memData = 32'h8C000000;
        tick(); tick();
        chk("rst_cmd", 32'(cmd), 32'd9);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_sticky", 32'(illegalSticky), 32'd0);
        chk("rst_cnt", 32'(instrCount), 32'd0);
        chk("rst_jaddr", 32'(jAddr), 32'h20);
        chk("rst_sxi", sxi, 32'h20);
        chk("rst_memcmd", 32'(memCmd), 32'd0);

        rst = 1'b0; irWe = 1'b1; memData = 32'h8D09FFFC;
        #1;
        chk("lw_memcmd", 32'(memCmd), 32'd0);
        tick(); irWe = 1'b0;
        chk("lw_cmd", 32'(cmd), 32'd0);
        chk("lw_rs", 32'(rs), 32'd8);
        chk("lw_rt", 32'(rt), 32'd9);
        chk("lw_sxi", sxi, 32'hFFFFFFFC);
        chk("lw_sxis", sxis, 32'hFFFFFFF0);
        chk("lw_cnt", 32'(instrCount), 32'd1);

        for (int i = 0; i < 4; i++) begin
            load({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, functs[i]});
            chk($sformatf("r%0d_cmd", i), 32'(cmd), 32'(rcmds[i]));
            chk($sformatf("r%0d_rd", i), 32'(rd), 32'd3);
            chk($sformatf("r%0d_ill", i), 32'(illegal), 32'd0);
        end
        chk("r_sticky0", 32'(illegalSticky), 32'd0);
        load(32'h00000000);
        chk("z_cmd", 32'(cmd), 32'd12);
        chk("z_ill", 32'(illegal), 32'd1);
        chk("z_sticky", 32'(illegalSticky), 32'd1);
        chk("z_cnt", 32'(instrCount), 32'd6);

        load(32'h10220005);
        memData = 32'h08000010; irWe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold%0d_cmd", i), 32'(cmd), 32'd5);
            chk($sformatf("hold%0d_sxis", i), sxis, 32'h14);
            chk($sformatf("hold%0d_mc", i), 32'(memCmd), 32'd2);
        end
        chk("hold_cnt", 32'(instrCount), 32'd7);
        load(32'h08000010);
        chk("j_cmd", 32'(cmd), 32'd2);
        chk("j_jaddr", 32'(jAddr), 32'h10);

        for (int i = 0; i < 8; i++) begin
            memData = mwords[i];
            #1;
            chk($sformatf("mc%0d", i), 32'(memCmd), 32'(mcmds[i]));
        end

        load(32'hFC000000);
        chk("ill_ill", 32'(illegal), 32'd1);
        load(32'h2021000A);
        chk("addi_ill", 32'(illegal), 32'd0);
        chk("addi_sticky", 32'(illegalSticky), 32'd1);
        chk("addi_cmd", 32'(cmd), 32'd8);
        chk("addi_sxi", sxi, 32'h0000000A);
        rst = 1'b1; irWe = 1'b1; memData = 32'hFC000000;
        tick();
        rst = 1'b0; irWe = 1'b0;
        chk("rst2_sticky", 32'(illegalSticky), 32'd0);
        chk("rst2_cnt", 32'(instrCount), 32'd0);
        chk("rst2_cmd", 32'(cmd), 32'd9);
        chk("rst2_ill", 32'(illegal), 32'd0);

        chk("sat_start", 32'(instrCountS), 32'd0);
        memData = 32'h00221820;
        irWeS = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("sat%0d", i), 32'(instrCountS),
                (i < 7) ? 32'(i + 1) : 32'd7);
        end
        irWeS = 1'b0;
        tick();
        chk("sat_hold", 32'(instrCountS), 32'd7);
        chk("sat_main_idle", 32'(instrCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
